// File: rtl/tspi_block_responder.sv
// Transparent-SPI block window responder: streams whole blocks between
// the block-swap controller strobes and the SD byte engine over OBI.
package tspi_pkg;
  localparam logic [31:0] UserTransparentSpiAddrOffset = 32'h4000_0000;
  localparam logic [31:0] BLOCK_READWRITE_MIN_OFFSET = 32'h0020_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    sbr_obi_a_chan_t a;
    logic            req;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    sbr_obi_r_chan_t r;
    logic            gnt;
    logic            rvalid;
  } sbr_obi_rsp_t;
endpackage

module tspi_block_responder
  import tspi_pkg::*;
#(
  parameter int unsigned NumWords = 128,
  parameter logic [31:0] BlockBase =
    UserTransparentSpiAddrOffset + BLOCK_READWRITE_MIN_OFFSET,
  parameter int unsigned WindowBits = 21,
  parameter logic [31:0] StatusAddr = 32'h5FFF_FFE4,
  parameter int unsigned HandshakeGap = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  sbr_obi_req_t          obi_req_i,
  output sbr_obi_rsp_t          obi_rsp_o,
  input  logic [31:0]           write_data_i,
  output logic                  signal_next_write_data_o,
  output logic [31:0]           read_data_o,
  output logic                  signal_next_read_data_o,
  output logic                  blk_start_o,
  input  logic                  blk_ready_i,
  output logic                  blk_we_o,
  output logic [WindowBits-1:0] blk_addr_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic [31:0]           tx_data_o,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  input  logic [31:0]           rx_data_i,
  input  logic                  blk_done_i,
  input  logic                  blk_err_i,
  input  logic                  engine_busy_i
);
  localparam int unsigned CW = $clog2(NumWords);
  localparam int unsigned GW = $clog2(HandshakeGap);
  localparam logic [CW-1:0] LastCnt = CW'(NumWords - 1);
  localparam logic [GW-1:0] LastGap = GW'(HandshakeGap - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_STATUS, S_DECERR, S_START,
    S_W_PULL, S_W_GAP, S_W_PUSH,
    S_R_WAIT, S_R_SETUP, S_R_PULSE, S_R_GAP,
    S_DONE_WAIT, S_GNT, S_RSP
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [GW-1:0]         gap_cnt;
  logic [WindowBits-1:0] addr_q;
  logic                  we_q;
  logic [3:0]            aid_q;
  logic                  done_q;
  logic                  err_q;
  logic                  err_sticky;
  logic                  rvalid_q;
  logic                  nwd_q;
  logic                  nrd_q;
  logic                  start_q;
  logic                  tx_valid_q;
  logic                  push_first_q;
  logic [31:0]           tx_data_q;
  logic                  rx_ready_q;
  logic [31:0]           read_data_q;

  logic [31:0] addr_off;
  logic        is_status;
  logic        is_block;
  logic        in_block;
  logic        sticky_set;
  logic        unused_ok;

  assign addr_off  = obi_req_i.a.addr - BlockBase;
  assign is_status = obi_req_i.a.addr == StatusAddr;
  assign is_block  = !is_status && (addr_off[31:WindowBits] == '0);
  assign in_block  = state inside {S_START, S_W_PULL, S_W_GAP,
                                   S_W_PUSH, S_R_WAIT, S_R_SETUP,
                                   S_R_PULSE, S_R_GAP, S_DONE_WAIT};
  assign sticky_set = (state == S_DECERR) || (state == S_RSP && err_q);
  assign unused_ok  = ^{obi_req_i.a.wdata, obi_req_i.a.be};

  // Block FSM with registered strobes, handshakes and capture state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      gap_cnt      <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      aid_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_sticky   <= 1'b0;
      rvalid_q     <= 1'b0;
      nwd_q        <= 1'b0;
      nrd_q        <= 1'b0;
      start_q      <= 1'b0;
      tx_valid_q   <= 1'b0;
      push_first_q <= 1'b0;
      tx_data_q    <= '0;
      rx_ready_q   <= 1'b0;
      read_data_q  <= '0;
    end else begin
      rvalid_q     <= 1'b0;
      nwd_q        <= 1'b0;
      nrd_q        <= 1'b0;
      push_first_q <= 1'b0;
      if (in_block && blk_done_i) begin
        done_q <= 1'b1;
        err_q  <= blk_err_i;
      end
      if (sticky_set) begin
        err_sticky <= 1'b1;
      end else if (state == S_STATUS) begin
        err_sticky <= 1'b0;
      end
      unique case (state)
        S_IDLE: begin
          if (obi_req_i.req) begin
            aid_q <= obi_req_i.a.aid;
            unique case (1'b1)
              is_status: begin
                state    <= S_STATUS;
                rvalid_q <= 1'b1;
              end
              is_block: begin
                addr_q  <= addr_off[WindowBits-1:0];
                we_q    <= obi_req_i.a.we;
                cnt     <= '0;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
                start_q <= 1'b1;
                state   <= S_START;
              end
              default: begin
                state    <= S_DECERR;
                rvalid_q <= 1'b1;
              end
            endcase
          end
        end
        S_STATUS, S_DECERR: state <= S_IDLE;
        S_START: begin
          if (blk_ready_i) begin
            start_q <= 1'b0;
            if (we_q) begin
              state <= S_W_PULL;
              nwd_q <= 1'b1;
            end else begin
              state      <= S_R_WAIT;
              rx_ready_q <= 1'b1;
            end
          end
        end
        S_W_PULL: begin
          state   <= S_W_GAP;
          gap_cnt <= '0;
        end
        S_W_GAP: begin
          if (gap_cnt == LastGap) begin
            state        <= S_W_PUSH;
            tx_valid_q   <= 1'b1;
            push_first_q <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_W_PUSH: begin
          if (push_first_q) tx_data_q <= write_data_i;
          if (tx_ready_i) begin
            tx_valid_q <= 1'b0;
            if (cnt == LastCnt) begin
              state <= S_DONE_WAIT;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= S_W_PULL;
              nwd_q <= 1'b1;
            end
          end
        end
        S_R_WAIT: begin
          if (rx_valid_i) begin
            rx_ready_q  <= 1'b0;
            read_data_q <= rx_data_i;
            state       <= S_R_SETUP;
          end
        end
        S_R_SETUP: begin
          state <= S_R_PULSE;
          nrd_q <= 1'b1;
        end
        S_R_PULSE: begin
          state   <= S_R_GAP;
          gap_cnt <= '0;
        end
        S_R_GAP: begin
          if (gap_cnt == LastGap) begin
            if (cnt == LastCnt) begin
              state <= S_DONE_WAIT;
            end else begin
              cnt        <= cnt + 1'b1;
              state      <= S_R_WAIT;
              rx_ready_q <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_DONE_WAIT: if (done_q) state <= S_GNT;
        S_GNT: begin
          if (obi_req_i.req) begin
            state    <= S_RSP;
            rvalid_q <= 1'b1;
          end
        end
        S_RSP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // OBI response: grant follows req in the decode or block-grant cycle.
  always_comb begin
    obi_rsp_o = '0;
    obi_rsp_o.gnt = !rst_i && obi_req_i.req &&
                    ((state == S_IDLE && !is_block) || state == S_GNT);
    obi_rsp_o.rvalid = rvalid_q;
    if (rvalid_q) begin
      obi_rsp_o.r.rid = aid_q;
      obi_rsp_o.r.err = (state == S_DECERR) || (state == S_RSP && err_q);
      if (state == S_STATUS) begin
        obi_rsp_o.r.rdata = {30'b0, err_sticky, engine_busy_i};
      end
    end
  end

  assign signal_next_write_data_o = nwd_q;
  assign signal_next_read_data_o  = nrd_q;
  assign read_data_o = read_data_q;
  assign blk_start_o = start_q;
  assign blk_we_o    = we_q;
  assign blk_addr_o  = addr_q;
  assign tx_valid_o  = tx_valid_q;
  assign tx_data_o   = push_first_q ? write_data_i : tx_data_q;
  assign rx_ready_o  = rx_ready_q;
endmodule

// File: tb/tb_tspi_block_responder.sv
// Directed bench for tspi_block_responder: status/decode table plus
// block write/read sequences against controller and engine models.
module tb_tspi_block_responder;
  import tspi_pkg::*;

  localparam int NW = 128;
  localparam int GAP = 2;
  localparam logic [31:0] BASE = 32'h4020_0000;
  localparam logic [31:0] STAT = 32'h5FFF_FFE4;

  logic         clk = 1'b0;
  logic         rst;
  sbr_obi_req_t obi_req;
  sbr_obi_rsp_t obi_rsp;
  logic [31:0]  write_data;
  logic         nwd;
  logic [31:0]  read_data;
  logic         nrd;
  logic         blk_start;
  logic         blk_ready;
  logic         blk_we;
  logic [20:0]  blk_addr;
  logic         tx_valid;
  logic         tx_ready;
  logic [31:0]  tx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [31:0]  rx_data;
  logic         blk_done;
  logic         blk_err;
  logic         busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tspi_block_responder dut (
    .clk_i                    (clk),
    .rst_i                    (rst),
    .obi_req_i                (obi_req),
    .obi_rsp_o                (obi_rsp),
    .write_data_i             (write_data),
    .signal_next_write_data_o (nwd),
    .read_data_o              (read_data),
    .signal_next_read_data_o  (nrd),
    .blk_start_o              (blk_start),
    .blk_ready_i              (blk_ready),
    .blk_we_o                 (blk_we),
    .blk_addr_o               (blk_addr),
    .tx_valid_o               (tx_valid),
    .tx_ready_i               (tx_ready),
    .tx_data_o                (tx_data),
    .rx_valid_i               (rx_valid),
    .rx_ready_o               (rx_ready),
    .rx_data_i                (rx_data),
    .blk_done_i               (blk_done),
    .blk_err_i                (blk_err),
    .engine_busy_i            (busy)
  );

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    obi_req = '0;
    write_data = '0;
    blk_ready = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data = '0;
    blk_done = 1'b0;
    blk_err = 1'b0;
  endtask

  task automatic status_txn(input string nm, input logic [31:0] addr,
                            input logic bsy, input logic [3:0] aid,
                            input logic exp_err,
                            input logic [31:0] exp_rdata);
    obi_req.req = 1'b1;
    obi_req.a.addr = addr;
    obi_req.a.we = 1'b0;
    obi_req.a.aid = aid;
    busy = bsy;
    @(negedge clk);
    check({nm, ".gnt"}, obi_rsp.gnt, 1);
    check({nm, ".rvalid0"}, obi_rsp.rvalid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check({nm, ".rvalid"}, obi_rsp.rvalid, 1);
    check({nm, ".gnt_in_rvalid"}, obi_rsp.gnt, 0);
    check({nm, ".err"}, obi_rsp.r.err, exp_err);
    check({nm, ".rdata"}, obi_rsp.r.rdata, exp_rdata);
    check({nm, ".rid"}, obi_rsp.r.rid, aid);
    @(posedge clk); #1;
    obi_req.req = 1'b0;
  endtask

  task automatic run_block(input string nm, input bit we,
                           input logic [20:0] off, input bit stall,
                           input int err_word, input int abort_word,
                           input bit drop_req, input bit exp_err);
    int txn = 0, strobes = 0, rdn = 0, rxn = 0;
    int pend = 0, widx = 0;
    int last_ws = -100, last_rs = -100;
    int start_cyc = 0, gcyc = -1;
    int tx_stall = 0, rx_stall = 0;
    bit started = 0, hs = 0, gseen = 0, finished = 0;
    bit done_sent = 0, aborted = 0;
    logic [31:0] prev_rd = '0;
    clear_inputs();
    obi_req.req = 1'b1;
    obi_req.a.addr = BASE + {11'b0, off};
    obi_req.a.we = we;
    obi_req.a.aid = 4'hA;
    tx_ready = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (c == 0) check({nm, ".no_gnt_at_decode"}, obi_rsp.gnt, 0);
      if (blk_start && !started) begin
        started = 1;
        start_cyc = c;
        check({nm, ".blk_addr"}, blk_addr, off);
        check({nm, ".blk_we"}, blk_we, we);
      end
      if (blk_start && blk_ready) hs = 1;
      if (nwd) begin
        if (c - last_ws < GAP + 2) check({nm, ".wstrobe_gap"}, c - last_ws, GAP + 2);
        last_ws = c;
        strobes++;
        pend = 2;
      end
      if (tx_valid && tx_ready) begin
        check({nm, ".tx_data"}, tx_data, 32'(txn * 3));
        txn++;
        tx_stall = stall ? $urandom_range(0, 5) : 0;
      end
      if (rx_ready && rx_valid) begin
        rxn++;
        rx_stall = stall ? $urandom_range(0, 5) : 0;
      end
      if (nrd) begin
        if (c - last_rs < GAP + 2) check({nm, ".rstrobe_gap"}, c - last_rs, GAP + 2);
        last_rs = c;
        check({nm, ".read_data"}, read_data, 32'h0000_A000 + 32'(rdn));
        check({nm, ".read_data_pre"}, prev_rd, 32'h0000_A000 + 32'(rdn));
        rdn++;
      end
      prev_rd = read_data;
      if (obi_rsp.gnt && !gseen) begin
        check({nm, ".words_at_gnt"}, we ? txn : rdn, NW);
        if (we) check({nm, ".wstrobes"}, strobes, NW);
        gseen = 1;
        gcyc = c;
      end else if (gseen && c == gcyc + 1) begin
        check({nm, ".rvalid"}, obi_rsp.rvalid, 1);
        check({nm, ".rsp_err"}, obi_rsp.r.err, exp_err);
        check({nm, ".rid"}, obi_rsp.r.rid, 4'hA);
        check({nm, ".rdata"}, obi_rsp.r.rdata, 0);
        finished = 1;
      end else if (obi_rsp.rvalid) begin
        check({nm, ".stray_rvalid"}, obi_rsp.rvalid, 0);
      end
      if (abort_word >= 0 && rxn == abort_word && !finished) begin
        rst = 1'b1;
        obi_req.req = 1'b0;
        #1;
        check({nm, ".rst_ctrl_zero"},
              {obi_rsp.gnt, obi_rsp.rvalid, obi_rsp.r.err, nwd, nrd,
               blk_start, blk_we, tx_valid, rx_ready}, 0);
        check({nm, ".rst_rdata_zero"}, {obi_rsp.r.rdata, obi_rsp.r.rid}, 0);
        check({nm, ".rst_read_data_zero"}, read_data, 0);
        check({nm, ".rst_blk_addr_zero"}, blk_addr, 0);
        check({nm, ".rst_tx_data_zero"}, tx_data, 0);
        finished = 1;
        aborted = 1;
      end
      if (finished) break;
      @(posedge clk); #1;
      obi_req.req = (drop_req && c >= 5 && c < 300) ? 1'b0 : !gseen;
      blk_ready = started && !hs && (c - start_cyc >= 2);
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          write_data = 32'(widx * 3);
          widx++;
        end else begin
          write_data = 32'hBAD0_0000 | 32'(widx);
        end
      end
      if (tx_stall > 0) begin
        tx_ready = 1'b0;
        tx_stall--;
      end else begin
        tx_ready = 1'b1;
      end
      if (rx_stall > 0) begin
        rx_valid = 1'b0;
        rx_stall--;
      end else begin
        rx_valid = rxn < NW;
        rx_data = 32'h0000_A000 + 32'(rxn);
      end
      blk_done = 1'b0;
      blk_err = 1'b0;
      if (!done_sent && ((err_word >= 0 && txn == err_word) ||
          (err_word < 0 && (we ? txn == NW : rxn == NW)))) begin
        blk_done = 1'b1;
        blk_err = err_word >= 0;
        done_sent = 1;
      end
    end
    if (!finished) check({nm, ".timeout"}, 1, 0);
    @(posedge clk); #1;
    clear_inputs();
    if (aborted) rst = 1'b0;
  endtask

  typedef struct {
    string       nm;
    logic [31:0] addr;
    logic        bsy;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"stat_busy", STAT, 1'b1, 1'b0, 32'h1};
    vecs[1] = '{"stat_idle", STAT, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{"decerr_below", BASE - 32'd4, 1'b0, 1'b1, 32'h0};
    vecs[3] = '{"stat_sticky", STAT, 1'b0, 1'b0, 32'h2};
    vecs[4] = '{"stat_cleared", STAT, 1'b1, 1'b0, 32'h1};
    vecs[5] = '{"decerr_zero", 32'h0, 1'b0, 1'b1, 32'h0};
    vecs[6] = '{"decerr_above", BASE + 32'h0020_0000, 1'b0, 1'b1, 32'h0};
    vecs[7] = '{"stat_sticky_busy", STAT, 1'b1, 1'b0, 32'h3};
    vecs[8] = '{"stat_idle2", STAT, 1'b0, 1'b0, 32'h0};

    rst = 1'b1;
    busy = 1'b1;
    clear_inputs();
    obi_req.req = 1'b1;
    obi_req.a.addr = STAT;
    @(negedge clk);
    check("reset.ctrl_zero",
          {obi_rsp.gnt, obi_rsp.rvalid, obi_rsp.r.err, nwd, nrd,
           blk_start, blk_we, tx_valid, rx_ready}, 0);
    check("reset.data_zero", {read_data, tx_data, blk_addr}, 0);
    check("reset.rdata_zero", obi_rsp.r.rdata, 0);
    obi_req.req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      status_txn(vecs[i].nm, vecs[i].addr, vecs[i].bsy, 4'(i),
                 vecs[i].exp_err, vecs[i].exp_rdata);
    end

    busy = 1'b0;
    run_block("wr", 1'b1, 21'h200, 1'b0, -1, -1, 1'b0, 1'b0);
    status_txn("stat_after_wr", STAT, 1'b0, 4'h1, 1'b0, 32'h0);
    run_block("rd", 1'b0, 21'h1000, 1'b1, -1, -1, 1'b1, 1'b0);
    run_block("wr_err", 1'b1, 21'h040, 1'b0, 120, -1, 1'b0, 1'b1);
    status_txn("stat_err_set", STAT, 1'b1, 4'h2, 1'b0, 32'h3);
    status_txn("stat_err_clr", STAT, 1'b1, 4'h3, 1'b0, 32'h1);
    status_txn("decerr_pre_abort", 32'h1234_5678, 1'b0, 4'h4, 1'b1, 32'h0);
    run_block("rd_abort", 1'b0, 21'h0, 1'b0, -1, 60, 1'b0, 1'b0);
    @(posedge clk); #1;
    status_txn("stat_after_rst", STAT, 1'b0, 4'h5, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/tspi_block_responder.md
# tspi_block_responder

OBI subordinate at the transparent-SPI block read/write window. It serves whole-block transfer requests issued by the block-swap controller. For each request it streams `NumWords` 32-bit words between the controller's next-data strobe handshake and the SD byte engine. It holds grant until the block completes, and it answers status polls that report engine busy and a sticky error bit.

## Interface
Parameters:
- `NumWords`, 128: words per block. Counter width is `$clog2(NumWords)`.
- `BlockBase`, `UserTransparentSpiAddrOffset + BLOCK_READWRITE_MIN_OFFSET`: base of the block window.
- `WindowBits`, 21: the window spans `2**WindowBits` bytes. The block address is `addr - BlockBase`, width `[20:0]`.
- `StatusAddr`, 32'h5FFF_FFE4: address of the status word.
- `HandshakeGap`, 2: number of idle cycles after each strobe pulse. Minimum value is 2.

Ports:
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: reset, asynchronous and active-high.
- `obi_req_i`, in, `sbr_obi_req_t`: request fields `req`, `a.addr`, `a.we`, `a.aid`. `wdata` and `be` are ignored.
- `obi_rsp_o`, out, `sbr_obi_rsp_t`: response fields `gnt`, `rvalid`, `r.rdata`, `r.err`, `r.rid`.
- `write_data_i`, in, 32: word supplied by the controller (SRAM to SD direction).
- `signal_next_write_data_o`, out, 1: one-cycle pulse that requests the next write word.
- `read_data_o`, out, 32: word presented to the controller (SD to SRAM direction).
- `signal_next_read_data_o`, out, 1: one-cycle pulse that tells the controller `read_data_o` is valid.
- `blk_start_o` / `blk_ready_i`, out / in, 1: start handshake to the byte engine.
- `blk_we_o`, out, 1: direction of the block transfer.
- `blk_addr_o`, out, 21: block address for the transfer.
- `tx_valid_o` / `tx_ready_i`, out / in, 1: handshake for words sent to the engine.
- `tx_data_o`, out, 32: word sent to the engine.
- `rx_valid_i` / `rx_ready_o`, in / out, 1: handshake for words received from the engine.
- `rx_data_i`, in, 32: word received from the engine.
- `blk_done_i`, in, 1: pulse when the engine finishes the block.
- `blk_err_i`, in, 1: qualified by `blk_done_i`.
- `engine_busy_i`, in, 1: level; the engine is still busy (card programming).

## Operation
- Address decode happens only in IDLE, when `req` is high:
  - `addr == StatusAddr`: STATUS.
  - `addr` inside the block window: the `addr`, `we` and `aid` are captured, the word count is cleared, and the FSM goes to START.
  - Any other address: DECERR. This sets the sticky error and responds with `err=1`.
- STATUS and DECERR: `gnt=1` in the decode cycle, `rvalid=1` in the next cycle.
  - Status `rdata` is `{30'b0, err_sticky, engine_busy_i}`.
  - A status read clears `err_sticky` in its rvalid cycle. If a set event occurs in the same cycle, the set wins.
- START: hold `blk_start_o`, `blk_we_o` and `blk_addr_o` until the cycle in which `blk_ready_i` is high. Then go to W_PULL if `we=1`, otherwise to R_WAIT.
- Write loop:
  - W_PULL: drive `signal_next_write_data_o` high for one cycle.
  - GAP: hold for `HandshakeGap` cycles with the strobe low.
  - W_PUSH: set `tx_valid_o=1` with `tx_data_o = write_data_i` sampled in the first W_PUSH cycle. Hold both until `tx_ready_i`.
  - After the push, if count == `NumWords-1` go to DONE_WAIT. Otherwise increment count and return to W_PULL.
- Read loop:
  - R_WAIT: `rx_ready_o=1`. When `rx_valid_i` is high, register `rx_data_i` into `read_data_o`.
  - R_SETUP: one cycle with the data stable.
  - R_PULSE: `signal_next_read_data_o=1` for one cycle.
  - GAP: `HandshakeGap` cycles.
  - Then DONE_WAIT if the last word was transferred, otherwise increment count and return to R_WAIT.
  - `read_data_o` holds its value until the next capture.
- A done flag latches `blk_done_i` in any state from START onward, so an early done is not lost. `blk_err_i` is latched on done as `blk_err_q`.
- DONE_WAIT: wait for the latched done flag, then go to GNT.
- GNT: assert `gnt` in the first cycle that `req` is high.
- RSP: `rvalid=1`, `r.err=blk_err_q`, `r.rid` = captured aid, `rdata=0`. Set `err_sticky` if `blk_err_q` is set. Return to IDLE.
- If `req` drops during a block, the transfer still completes. GNT waits for `req` to return.

## Timing
- Reset (async, `rst_i=1`): FSM goes to IDLE. Every output is 0, including `read_data_o`, the strobes, `gnt`, `rvalid`, and `blk_*`/`tx_*`/`rx_ready_o`. Count, flags and `err_sticky` clear. Reset in mid-block abandons the block and no response is issued.
- Both strobes are exactly one cycle wide. Consecutive pulses are separated by at least `HandshakeGap+1` low cycles (the controller detects edges).
- Write word latency: `write_data_i` is sampled `HandshakeGap+1` cycles after the pulse. The controller's SRAM fetch takes 2 cycles.
- Read word: `read_data_o` is stable from one cycle before the pulse until at least `HandshakeGap` cycles after it.
- Grant latency: `gnt` for a block transfer is never issued before the block has finished. `rvalid` always follows `gnt` by exactly 1 cycle. The FSM never grants in the rvalid cycle.
- Minimum block duration with zero engine stall:
  - Write: `NumWords*(HandshakeGap+2)` cycles plus start and response.
  - Read: `NumWords*(HandshakeGap+3)` cycles plus start and response.

## Test plan
- Status poll at 0x5FFF_FFE4 with `engine_busy_i=1` and no prior error -> `gnt` in cycle 0, `rvalid` in cycle 1, `rdata=32'h1`, `err=0`.
- Block write at `BlockBase+21'h200` with the controller model returning words i*3 -> `blk_addr_o=0x200` and `blk_we_o=1`. 128 `tx` words equal to i*3 in order, 128 write strobes, then `gnt`, then `rvalid` with `err=0`.
- Block read with the engine supplying 128 words 0xA000+i and `tx`/`rx` stalls of random length 0-5 -> 128 read pulses. `read_data_o` equals 0xA000+i at each pulse and the cycle before it. Response `err=0`.
- `blk_done_i` with `blk_err_i=1` arrives during word 120 of a write -> the transfer still sends 128 words and the response has `err=1`. The next status read returns bit1=1; the read after that returns bit1=0.
- Access to `BlockBase-4` -> immediate `gnt`, `rvalid` with `err=1`, and the sticky error is set.
- `rst_i` pulsed at word 60 of a read -> all outputs are 0 immediately. A following status read works and returns `err_sticky=0`.
